// File: rtl/uart_loopback_ctrl.sv
// Avalon-MM master that polls the rs232_0 slave and echoes each received byte
// back out, optionally XOR-transformed, with rx/tx/drop counters for bring-up.
module uart_loopback_ctrl #(
  parameter int unsigned POLL_DIV   = 64,
  parameter int unsigned TX_TIMEOUT = 255,
  parameter logic [7:0]  XOR_MASK   = 8'h00
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count,
  output logic [7:0]  drop_count,
  output logic        drop_pulse
);

  localparam int PW = (POLL_DIV   > 1) ? $clog2(POLL_DIV)   : 1;
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    INIT, IDLE, RD_DATA, RD_DATA_W, RD_CTRL, RD_CTRL_W, WR_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  logic        addr_c, cs_c, rd_c, wr_c, drop_c;
  logic [3:0]  be_c;
  logic [31:0] wd_c;

  // Only RVALID, the RX byte and WSPACE are consumed from readdata.
  logic unused_rd;
  assign unused_rd = ^avm_readdata[14:8];

  always_comb begin
    state_d      = state_q;
    poll_d       = poll_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    rx_count_d   = rx_count_q;
    tx_count_d   = tx_count_q;
    drop_count_d = drop_count_q;
    addr_c       = 1'b0;
    cs_c         = 1'b0;
    rd_c         = 1'b0;
    wr_c         = 1'b0;
    drop_c       = 1'b0;
    be_c         = 4'h0;
    wd_c         = 32'h0;
    case (state_q)
      INIT: begin
        // Clear RE/WE so the UART never raises interrupts at us.
        wr_c    = 1'b1;
        cs_c    = 1'b1;
        addr_c  = 1'b1;
        be_c    = 4'hF;
        state_d = IDLE;
      end
      IDLE: begin
        if (!enable) begin
          poll_d = '0;
        end else if (poll_q == PW'(POLL_DIV - 1)) begin
          poll_d  = '0;
          state_d = RD_DATA;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      RD_DATA: begin
        rd_c    = 1'b1;
        cs_c    = 1'b1;
        be_c    = 4'hF;
        state_d = RD_DATA_W;
      end
      RD_DATA_W: begin
        if (avm_readdata[15]) begin
          hold_d     = avm_readdata[7:0];
          rx_count_d = rx_count_q + 16'd1;
          tmo_d      = '0;
          state_d    = RD_CTRL;
        end else begin
          state_d = IDLE;
        end
      end
      RD_CTRL: begin
        rd_c    = 1'b1;
        cs_c    = 1'b1;
        addr_c  = 1'b1;
        be_c    = 4'hF;
        state_d = RD_CTRL_W;
      end
      RD_CTRL_W: begin
        if (avm_readdata[31:16] != 16'h0) begin
          state_d = WR_DATA;
        end else if (tmo_q == TW'(TX_TIMEOUT - 1)) begin
          drop_c  = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
          if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end else begin
          tmo_d   = tmo_q + 1'b1;
          state_d = RD_CTRL;
        end
      end
      WR_DATA: begin
        wr_c       = 1'b1;
        cs_c       = 1'b1;
        be_c       = 4'b0001;
        wd_c       = {24'h0, hold_q ^ XOR_MASK};
        tx_count_d = tx_count_q + 16'd1;
        // Re-poll immediately so a queued burst drains without the idle gap.
        state_d    = enable ? RD_DATA : IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= INIT;
      poll_q       <= '0;
      tmo_q        <= '0;
      hold_q       <= 8'h00;
      rx_count_q   <= 16'h0;
      tx_count_q   <= 16'h0;
      drop_count_q <= 8'h0;
    end else begin
      state_q      <= state_d;
      poll_q       <= poll_d;
      tmo_q        <= tmo_d;
      hold_q       <= hold_d;
      rx_count_q   <= rx_count_d;
      tx_count_q   <= tx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Strobes are decoded from state; reset masks them so nothing toggles while held.
  assign avm_address    = addr_c & ~reset_reset;
  assign avm_chipselect = cs_c   & ~reset_reset;
  assign avm_read       = rd_c   & ~reset_reset;
  assign avm_write      = wr_c   & ~reset_reset;
  assign avm_byteenable = reset_reset ? 4'h0  : be_c;
  assign avm_writedata  = reset_reset ? 32'h0 : wd_c;
  assign drop_pulse     = drop_c & ~reset_reset;
  assign busy           = (state_q != IDLE) & ~reset_reset;
  assign rx_count       = rx_count_q;
  assign tx_count       = tx_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Randomized bench: a UART slave model with a byte queue and per-byte WSPACE
// plans predicts every bus strobe, its cycle, and the counters.
module tb_uart_loopback_ctrl;
  localparam int         PD   = 4;
  localparam int         TO   = 3;
  localparam logic [7:0] MASK = 8'h20;

  logic        clk_clk = 1'b0;
  logic        reset_reset, enable;
  logic        avm_address, avm_chipselect, avm_read, avm_write, busy, drop_pulse;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic [15:0] rx_count, tx_count;
  logic [7:0]  drop_count;

  uart_loopback_ctrl #(.POLL_DIV(PD), .TX_TIMEOUT(TO), .XOR_MASK(MASK)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .busy(busy),
    .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count),
    .drop_pulse(drop_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [7:0] rxq[$];
  int         zq[$];
  logic [7:0] cur_b;
  int cur_z, ctrl_n, last_pop;
  int exp_rd, exp_wr, exp_drop, exp_init;
  logic [15:0] exp_rx, exp_tx;
  logic [7:0]  exp_dc;
  bit saw_rd1, saw_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Compare this cycle's bus activity with the model, then act as the slave.
  task automatic sample();
    logic rd0, rd1, wr0;
    rd0 = avm_read  && !avm_address;
    rd1 = avm_read  &&  avm_address;
    wr0 = avm_write && !avm_address;
    chk("rw_excl", avm_read & avm_write, 0);
    chk("cs", avm_chipselect, avm_read | avm_write);
    if (avm_read) chk("rd_be", avm_byteenable, 4'hF);
    chk("init_wr", avm_write && avm_address, cyc == exp_init);
    chk("rd_time", rd0, cyc == exp_rd);
    chk("wr_time", wr0, cyc == exp_wr);
    chk("drop_time", drop_pulse, cyc == exp_drop);
    if (avm_write && avm_address) begin
      chk("init_data", avm_writedata, 32'h0);
      chk("init_be", avm_byteenable, 4'hF);
      chk("init_busy", busy, 1);
      exp_init = -1;
      exp_rd = enable ? cyc + 1 + PD : -1;
    end
    if (rd0) begin
      if (rxq.size() > 0) begin
        cur_b = rxq.pop_front();
        cur_z = zq.pop_front();
        avm_readdata = {16'(rxq.size()), 8'h80, cur_b};
        exp_rx++;
        ctrl_n = 0;
        last_pop = cyc;
        exp_rd = -1;
        if (cur_z < TO) exp_wr = cyc + 4 + 2 * cur_z;
        else            exp_drop = cyc + 3 + 2 * (TO - 1);
      end else begin
        avm_readdata = {16'h0, 8'h00, 8'($urandom)};
        exp_rd = enable ? cyc + 2 + PD : -1;
      end
    end
    if (rd1) begin
      saw_rd1 = 1;
      ctrl_n++;
      if (ctrl_n <= cur_z) avm_readdata = {16'h0, 16'($urandom)};
      else avm_readdata = {16'($urandom_range(1, 65535)), 16'($urandom)};
    end
    if (wr0) begin
      saw_wr = 1;
      chk("wr_data", avm_writedata, {24'h0, cur_b ^ MASK});
      chk("wr_be", avm_byteenable, 4'b0001);
      chk("wr_polls", ctrl_n, cur_z + 1);
      chk("wr_rx_count", rx_count, exp_rx);
      chk("wr_tx_count", tx_count, exp_tx);
      exp_tx++;
      exp_wr = -1;
      exp_rd = enable ? cyc + 1 : -1;
    end
    if (drop_pulse) begin
      chk("drop_polls", ctrl_n, TO);
      if (exp_dc != 8'hFF) exp_dc++;
      exp_drop = -1;
      exp_rd = enable ? cyc + 1 + PD : -1;
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
    if (!reset_reset) sample();
    @(posedge clk_clk);
    #1;
    cyc++;
  endtask

  task automatic reset_tick();
    @(negedge clk_clk);
    chk("rst_strobes", {avm_read, avm_write, avm_chipselect, drop_pulse}, 0);
    chk("rst_bus", {avm_address, avm_byteenable, avm_writedata}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_counts", {rx_count, tx_count, drop_count}, 0);
    @(posedge clk_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_reset = 1;
    exp_rx = 0; exp_tx = 0; exp_dc = 0;
    exp_rd = -1; exp_wr = -1; exp_drop = -1; exp_init = -1;
    @(posedge clk_clk);
    #1;
    cyc++;
    repeat (2) reset_tick();
    reset_reset = 0;
    exp_init = cyc;
  endtask

  task automatic push(input logic [7:0] b, input int z);
    rxq.push_back(b);
    zq.push_back(z);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_rx"}, rx_count, exp_rx);
    chk({tag, "_tx"}, tx_count, exp_tx);
    chk({tag, "_drop"}, drop_count, exp_dc);
  endtask

  initial begin
    int budget;
    enable = 1;
    avm_readdata = 32'h0;
    cur_b = 0; cur_z = 0; ctrl_n = 0; last_pop = -100;
    do_reset();

    // Single byte, WSPACE free on first check.
    push(8'h41, 0);
    repeat (20) tick();
    chk_counts("single");

    // Burst of three drains back to back, then an empty poll.
    push(8'h11, 0); push(8'h22, 0); push(8'hA5, 0);
    repeat (30) tick();
    chk_counts("burst");

    // Timeout drop followed by a normal echo.
    push(8'h5A, TO); push(8'h3C, 0);
    repeat (40) tick();
    chk_counts("drop");

    // Random traffic with random control-poll depths.
    repeat (400) begin
      if ($urandom_range(0, 9) == 0) push(8'($urandom), $urandom_range(0, TO + 1));
      tick();
    end
    repeat (60) tick();
    chk_counts("random");

    // enable falls while waiting on WSPACE: the write still completes.
    saw_rd1 = 0; saw_wr = 0;
    push(8'hC3, 1);
    budget = 100;
    while (!saw_rd1 && budget > 0) begin tick(); budget--; end
    chk("en_wait_timeout", budget > 0, 1);
    enable = 0;
    push(8'h77, 0);
    repeat (25) begin
      tick();
      if (saw_wr) chk("dis_busy", busy, 0);
    end
    chk("dis_wr_seen", saw_wr, 1);
    enable = 1;
    exp_rd = cyc + PD;
    repeat (30) tick();
    chk_counts("reenable");

    // Reset lands in RD_CTRL: held byte lost, nothing counted as dropped.
    last_pop = -100;
    push(8'h99, 0);
    budget = 100;
    while (!(last_pop >= 0 && cyc == last_pop + 2) && budget > 0) begin tick(); budget--; end
    chk("rst_wait_timeout", budget > 0, 1);
    do_reset();
    repeat (20) tick();
    chk_counts("post_rst");

    // Enough drops to pin drop_count at its ceiling.
    repeat (258) push(8'($urandom), TO);
    budget = 5000;
    while ((rxq.size() > 0 || exp_drop >= 0) && budget > 0) begin tick(); budget--; end
    chk("sat_wait_timeout", budget > 0, 1);
    repeat (10) tick();
    chk_counts("sat");
    chk("sat_value", drop_count, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
